// File: rtl/fpadd_sched_pkg.sv
// fpadd_sched_pkg: shared types and widths for the serial FP-adder scheduler.
package fpadd_sched_pkg;

   localparam int OPW  = 32;   // IEEE-754 single operand / result width
   localparam int CNTW = 8;    // WAIT/COLLECT timeout counter width

   typedef enum logic [2:0] {
      IDLE,
      START,
      SEND_A,
      SEND_B,
      WAIT,
      COLLECT,
      RESP
   } state_e;

endpackage

// File: rtl/fpadd_sched_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter. The pointer favours req[0] out of
// reset and flips to favour the loser after every accepted grant.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic ptr_q, ptr_d;

   // Favoured requester wins if asking; otherwise a lone requester wins
   always_comb begin
      grant = 2'b00;
      if (ptr_q == 1'b0) begin
         grant[0] = req[0];
         grant[1] = req[1] & ~req[0];
      end else begin
         grant[1] = req[1];
         grant[0] = req[0] & ~req[1];
      end
   end

   // After a taken grant, favour the requester that did not win
   always_comb begin
      ptr_d = ptr_q;
      if (advance && (grant != 2'b00)) ptr_d = grant[0];
   end

   // Pointer register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ptr_q <= 1'b0;
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/fpadd_sched.sv
// fpadd_sched: arbitrates two operand requesters onto a bit-serial FP adder,
// streams a then b MSB-first, collects the serial result and presents it.
// Optional feature: define FPADD_SCHED_TIMEOUT_EN to abort an operation that
// sits TIMEOUT cycles in WAIT/COLLECT (adder reset pulse, rsp_err=1, rsp_c=0).
module fpadd_sched
   import fpadd_sched_pkg::*;
#(
   parameter int TIMEOUT = 160
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           req0_valid,
   input  logic           req1_valid,
   input  logic [OPW-1:0] req0_a,
   input  logic [OPW-1:0] req0_b,
   input  logic [OPW-1:0] req1_a,
   input  logic [OPW-1:0] req1_b,
   output logic           req0_ready,
   output logic           req1_ready,
   output logic           add_rst,
   output logic           add_go,
   output logic           add_inpab,
   input  logic           add_shift,
   input  logic           add_out_c,
   input  logic           add_over,
   input  logic           add_under,
   input  logic           add_done,
   output logic           rsp_valid,
   output logic           rsp_id,
   output logic           rsp_over,
   output logic           rsp_under,
   output logic           rsp_err,
   output logic [OPW-1:0] rsp_c,
   input  logic           rsp_ready
);

   state_e             state_q, state_d;
   logic [2*OPW-1:0]   op_q, op_d;        // {a,b}, shifted out from the MSB
   logic [5:0]         cnt_q, cnt_d;      // serial bit index 0..63
   logic [OPW-1:0]     rsp_c_q, rsp_c_d;
   logic               rsp_id_q, rsp_id_d;
   logic               rsp_over_q, rsp_over_d;
   logic               rsp_under_q, rsp_under_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic               add_rst_q, add_rst_d;
   logic               add_go_q, add_go_d;
   logic               add_inpab_q, add_inpab_d;
   logic               collect;
   logic [1:0]         arb_req, grant;
   logic               take;
`ifdef FPADD_SCHED_TIMEOUT_EN
   logic [CNTW-1:0]    tmo_q, tmo_d;
   logic               rsp_err_q, rsp_err_d;
`else
   localparam int unused_timeout = TIMEOUT;
`endif

   // add_rst_q stays high until the first edge after reset release, which
   // also keeps ready low for that first cycle
   assign arb_req    = {req1_valid, req0_valid} & {2{(state_q == IDLE) & ~add_rst_q}};
   assign take       = |grant;
   assign req0_ready = grant[0];
   assign req1_ready = grant[1];

   rr_arb2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (arb_req),
      .advance (take),
      .grant   (grant)
   );

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      cnt_d       = cnt_q;
      rsp_c_d     = rsp_c_q;
      rsp_id_d    = rsp_id_q;
      rsp_over_d  = rsp_over_q;
      rsp_under_d = rsp_under_q;
      add_rst_d   = 1'b0;
      collect     = 1'b0;
`ifdef FPADD_SCHED_TIMEOUT_EN
      tmo_d       = tmo_q;
      rsp_err_d   = rsp_err_q;
`endif
      case (state_q)
         IDLE: begin
            if (take) begin
               op_d        = grant[1] ? {req1_a, req1_b} : {req0_a, req0_b};
               rsp_id_d    = grant[1];
               rsp_c_d     = '0;
               rsp_over_d  = 1'b0;
               rsp_under_d = 1'b0;
`ifdef FPADD_SCHED_TIMEOUT_EN
               rsp_err_d   = 1'b0;
`endif
               state_d     = START;
            end
         end
         START: begin
            cnt_d   = '0;
`ifdef FPADD_SCHED_TIMEOUT_EN
            tmo_d   = '0;
`endif
            state_d = SEND_A;
         end
         SEND_A, SEND_B: begin
            op_d  = op_q << 1;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) state_d = SEND_B;
            if (cnt_q == 6'd63) state_d = WAIT;
         end
         // The first add_shift cycle in WAIT already counts as a COLLECT cycle
         WAIT:    collect = add_shift;
         COLLECT: collect = 1'b1;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (collect) begin
         if (add_shift) rsp_c_d = {rsp_c_q[OPW-2:0], add_out_c};
         state_d = COLLECT;
         if (add_done) begin
            rsp_over_d  = add_over;
            rsp_under_d = add_under;
            state_d     = RESP;
         end
      end

`ifdef FPADD_SCHED_TIMEOUT_EN
      // A normal completion in the same cycle takes priority over the abort
      if ((state_q == WAIT) || (state_q == COLLECT)) begin
         tmo_d = tmo_q + 1'b1;
         if ((state_d != RESP) && (tmo_q == CNTW'(TIMEOUT - 1))) begin
            state_d   = RESP;
            rsp_c_d   = '0;
            rsp_err_d = 1'b1;
            add_rst_d = 1'b1;
         end
      end
`endif

      rsp_valid_d = (state_d == RESP);
      add_go_d    = (state_d != START);
      add_inpab_d = ((state_d == SEND_A) || (state_d == SEND_B)) & op_d[2*OPW-1];
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         op_q        <= '0;
         cnt_q       <= '0;
         rsp_c_q     <= '0;
         rsp_id_q    <= 1'b0;
         rsp_over_q  <= 1'b0;
         rsp_under_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         add_rst_q   <= 1'b1;
         add_go_q    <= 1'b1;
         add_inpab_q <= 1'b0;
`ifdef FPADD_SCHED_TIMEOUT_EN
         tmo_q       <= '0;
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         cnt_q       <= cnt_d;
         rsp_c_q     <= rsp_c_d;
         rsp_id_q    <= rsp_id_d;
         rsp_over_q  <= rsp_over_d;
         rsp_under_q <= rsp_under_d;
         rsp_valid_q <= rsp_valid_d;
         add_rst_q   <= add_rst_d;
         add_go_q    <= add_go_d;
         add_inpab_q <= add_inpab_d;
`ifdef FPADD_SCHED_TIMEOUT_EN
         tmo_q       <= tmo_d;
         rsp_err_q   <= rsp_err_d;
`endif
      end
   end

   assign add_rst   = add_rst_q;
   assign add_go    = add_go_q;
   assign add_inpab = add_inpab_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_over  = rsp_over_q;
   assign rsp_under = rsp_under_q;
   assign rsp_c     = rsp_c_q;
`ifdef FPADD_SCHED_TIMEOUT_EN
   assign rsp_err   = rsp_err_q;
`else
   assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fpadd_sched.sv
// tb_fpadd_sched: scoreboard bench for fpadd_sched with a behavioural
// bit-serial adder driven from tasks.
`timescale 1ns/1ps
module tb_fpadd_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        req0_ready, req1_ready;
   logic        add_rst, add_go, add_inpab;
   logic        add_shift, add_out_c, add_over, add_under, add_done;
   logic        rsp_valid, rsp_id, rsp_over, rsp_under, rsp_err;
   logic [31:0] rsp_c;
   logic        rsp_ready;

   typedef struct packed {
      logic        id;
      logic [31:0] c;
      logic        ov;
      logic        un;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   grants[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   acc_cyc = 0;

   fpadd_sched #(.TIMEOUT(160)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .add_rst(add_rst), .add_go(add_go), .add_inpab(add_inpab),
      .add_shift(add_shift), .add_out_c(add_out_c), .add_over(add_over),
      .add_under(add_under), .add_done(add_done),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_over(rsp_over),
      .rsp_under(rsp_under), .rsp_err(rsp_err), .rsp_c(rsp_c),
      .rsp_ready(rsp_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Transfer monitor, sampled before the edge updates the DUT
   always @(posedge clk) begin
      if (reset) begin
         if (req0_valid && req0_ready) begin grants.push_back(0); acc_cyc <= cyc; end
         if (req1_valid && req1_ready) begin grants.push_back(1); acc_cyc <= cyc; end
      end
   end

   // Behavioural adder: checks start pulse and serial operands, returns res
   task automatic serve_op(input logic [31:0] res, input logic ov, input logic un,
                           input bit same_done, input logic [63:0] exp_ops,
                           input bit drop, input string nm);
      int n;
      int first_cyc;
      logic [63:0] rx;
      n = 0;
      rx = '0;
      first_cyc = 0;
      while (add_go !== 1'b0 && n < 300) begin @(negedge clk); n++; end
      checks++;
      if (add_go !== 1'b0) begin
         errors++;
         $display("FAIL %s start: add_go=%b after %0d cycles, required 0", nm, add_go, n);
         return;
      end
      if (drop) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      checks++;
      if (cyc - acc_cyc !== 1) begin
         errors++;
         $display("FAIL %s go_latency: got %0d, required 1", nm, cyc - acc_cyc);
      end
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (i == 0) begin
            first_cyc = cyc;
            checks++;
            if (add_go !== 1'b1) begin
               errors++;
               $display("FAIL %s go_width: add_go=%b in first bit cycle, required 1", nm, add_go);
            end
         end
         rx = {rx[62:0], add_inpab};
      end
      checks++;
      if (rx !== exp_ops) begin
         errors++;
         $display("FAIL %s serial_bits: got %h, required %h", nm, rx, exp_ops);
      end
      checks++;
      if ((first_cyc - acc_cyc !== 2) || (cyc - acc_cyc !== 65)) begin
         errors++;
         $display("FAIL %s bit_latency: first %0d last %0d, required 2 and 65", nm,
                  first_cyc - acc_cyc, cyc - acc_cyc);
      end
      repeat (3) @(negedge clk);
      for (int i = 31; i >= 0; i--) begin
         add_shift = 1'b1;
         add_out_c = res[i];
         add_over  = ov;
         add_under = un;
         add_done  = same_done && (i == 0);
         @(negedge clk);
      end
      add_shift = 1'b0;
      add_out_c = 1'b0;
      if (!same_done) begin
         add_done = 1'b1;
         @(negedge clk);
      end
      add_done  = 1'b0;
      add_over  = 1'b0;
      add_under = 1'b0;
   endtask

   // Wait for a response, compare against the scoreboard, let it be consumed
   task automatic check_rsp(input string nm);
      int n;
      exp_t e;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      checks++;
      if (rsp_valid !== 1'b1 || sb.size() == 0) begin
         errors++;
         $display("FAIL %s rsp_valid: got %b with %0d expected, required 1", nm, rsp_valid, sb.size());
         return;
      end
      e = sb.pop_front();
      checks++;
      if ({rsp_id, rsp_c, rsp_over, rsp_under, rsp_err} !== e) begin
         errors++;
         $display("FAIL %s rsp: id %b c %h ov %b un %b err %b, required id %b c %h ov %b un %b err %b",
                  nm, rsp_id, rsp_c, rsp_over, rsp_under, rsp_err, e.id, e.c, e.ov, e.un, e.err);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s rsp_release: rsp_valid=%b, required 0", nm, rsp_valid);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      add_shift = 1'b0; add_out_c = 1'b0; add_over = 1'b0; add_under = 1'b0; add_done = 1'b0;
      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
         errors++; $display("FAIL reset ready: got %b, required 00", {req0_ready, req1_ready});
      end
      checks++;
      if ({add_rst, add_go, add_inpab} !== 3'b110) begin
         errors++; $display("FAIL reset adder_ctl: rst/go/inpab %b, required 110", {add_rst, add_go, add_inpab});
      end
      checks++;
      if ({rsp_valid, rsp_id, rsp_over, rsp_under, rsp_err, rsp_c} !== 37'd0) begin
         errors++; $display("FAIL reset rsp: valid %b c %h, required all 0", rsp_valid, rsp_c);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (add_rst !== 1'b0) begin
         errors++; $display("FAIL reset add_rst_release: got %b, required 0", add_rst);
      end
   endtask

   task automatic test_basic();
      req0_a = 32'h3F780000; req0_b = 32'hBE780000;
      sb.push_back('{id: 1'b0, c: 32'h3F3A0000, ov: 1'b0, un: 1'b0, err: 1'b0});
      req0_valid = 1'b1;
      serve_op(32'h3F3A0000, 1'b0, 1'b0, 1'b0, {32'h3F780000, 32'hBE780000}, 1'b1, "basic");
      check_rsp("basic");
   endtask

   task automatic test_overflow();
      req1_a = 32'h7F000000; req1_b = 32'h7F000000;
      sb.push_back('{id: 1'b1, c: 32'h7F800000, ov: 1'b1, un: 1'b0, err: 1'b0});
      req1_valid = 1'b1;
      serve_op(32'h7F800000, 1'b1, 1'b0, 1'b1, {32'h7F000000, 32'h7F000000}, 1'b1, "overflow");
      check_rsp("overflow");
   endtask

   task automatic test_round_robin();
      logic [63:0] ops [2];
      logic [31:0] res;
      int          w;
      grants.delete();
      req0_a = 32'h40000000; req0_b = 32'h40400000;
      req1_a = 32'hC0A00000; req1_b = 32'h3F800000;
      ops[0] = {32'h40000000, 32'h40400000};
      ops[1] = {32'hC0A00000, 32'h3F800000};
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         w   = k % 2;
         res = 32'h41000000 + 32'(k);
         sb.push_back('{id: w[0], c: res, ov: 1'b0, un: (k == 2), err: 1'b0});
         serve_op(res, 1'b0, (k == 2), 1'b0, ops[w], (k == 3), "round_robin");
         check_rsp("round_robin");
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      checks++;
      if (grants.size() != 4 || grants[0] != 0 || grants[1] != 1 || grants[2] != 0 || grants[3] != 1) begin
         errors++;
         $display("FAIL round_robin order: %0d grants %p, required 0,1,0,1", grants.size(), grants);
      end
   endtask

   task automatic test_hold();
      req0_a = 32'h3F800000; req0_b = 32'h3F800000;
      req1_a = 32'h40800000; req1_b = 32'h40800000;
      rsp_ready = 1'b0;
      req0_valid = 1'b1;
      serve_op(32'h40000000, 1'b0, 1'b0, 1'b0, {32'h3F800000, 32'h3F800000}, 1'b1, "hold");
      req1_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (rsp_valid !== 1'b1 || rsp_c !== 32'h40000000 || req1_ready !== 1'b0 || req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold cycle %0d: valid %b c %h ready %b%b, required 1 40000000 00",
                     i, rsp_valid, rsp_c, req1_ready, req0_ready);
         end
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || req1_ready !== 1'b1) begin
         errors++;
         $display("FAIL hold release: valid %b req1_ready %b, required 0 1", rsp_valid, req1_ready);
      end
      sb.push_back('{id: 1'b1, c: 32'h41000000, ov: 1'b0, un: 1'b0, err: 1'b0});
      serve_op(32'h41000000, 1'b0, 1'b0, 1'b0, {32'h40800000, 32'h40800000}, 1'b1, "hold_next");
      check_rsp("hold_next");
   endtask

   task automatic test_reset_mid();
      int n;
      req0_a = 32'h12345678; req0_b = 32'h9ABCDEF0;
      req0_valid = 1'b1;
      n = 0;
      while (add_go !== 1'b0 && n < 20) begin @(negedge clk); n++; end
      req0_valid = 1'b0;
      repeat (40) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({add_go, add_rst, add_inpab, rsp_valid} !== 4'b1100) begin
         errors++;
         $display("FAIL reset_mid outputs: go/rst/inpab/valid %b, required 1100",
                  {add_go, add_rst, add_inpab, rsp_valid});
      end
      @(negedge clk);
      grants.delete();
      req0_a = 32'h3F000000; req0_b = 32'h3F000000;
      req1_a = 32'hDEADBEEF; req1_b = 32'hCAFEF00D;
      req0_valid = 1'b1; req1_valid = 1'b1;
      reset = 1'b1;
      sb.push_back('{id: 1'b0, c: 32'h3F800000, ov: 1'b0, un: 1'b0, err: 1'b0});
      serve_op(32'h3F800000, 1'b0, 1'b0, 1'b0, {32'h3F000000, 32'h3F000000}, 1'b1, "reset_mid");
      check_rsp("reset_mid");
      checks++;
      if (grants.size() != 1 || grants[0] != 0) begin
         errors++;
         $display("FAIL reset_mid pointer: grants %p, required single grant to 0", grants);
      end
   endtask

`ifdef FPADD_SCHED_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      exp_t e;
      req0_a = 32'h11111111; req0_b = 32'h22222222;
      req0_valid = 1'b1;
      n = 0;
      while (add_go !== 1'b0 && n < 20) begin @(negedge clk); n++; end
      req0_valid = 1'b0;
      repeat (64) @(negedge clk);
      e = '{id: 1'b0, c: 32'h0, ov: 1'b0, un: 1'b0, err: 1'b1};
      @(negedge clk);
      n = 0;
      while (rsp_valid !== 1'b1 && n < 400) begin @(negedge clk); n++; end
      checks++;
      if (n != 160 || add_rst !== 1'b1) begin
         errors++;
         $display("FAIL timeout timing: rsp after %0d WAIT cycles add_rst %b, required 160 and 1", n, add_rst);
      end
      checks++;
      if ({rsp_id, rsp_c, rsp_over, rsp_under, rsp_err} !== e) begin
         errors++;
         $display("FAIL timeout rsp: c %h err %b, required 00000000 1", rsp_c, rsp_err);
      end
      @(negedge clk);
      checks++;
      if (add_rst !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL timeout pulse: add_rst %b valid %b, required 0 0", add_rst, rsp_valid);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_round_robin();
      test_hold();
      test_reset_mid();
`ifdef FPADD_SCHED_TIMEOUT_EN
      test_timeout();
`endif
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: %0d responses missing, required 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
